id_ex_latch: RTL and testbench
==============================

# id_ex_latch

Pipeline register between decode (ID) and execute (EX) of the 5-stage MIPS core. It latches the ID-stage operands, applying the forwarding unit's bypass selections at capture time, and registers the control fields EX needs. It detects load-use hazards that forwarding cannot resolve and inserts a one-cycle bubble while stalling PC and IF/ID. It also honours the EX-stage flush and the debug enable, and keeps a saturating stall counter for the debug unit.

## Interface
- NB_REG_ADDR, 5: register address width
- NB_REG, 32: datapath width
- NB_OPCODE, 6: opcode width
- NB_STALL_CNT, 16: stall counter width

- i_clock  in  1  core clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug step enable; 0 holds all state
- i_flush  in  1  branch/jump resolved taken in EX; squash ID instruction
- i_valid  in  1  ID holds a real instruction
- i_data_a / i_data_b  in  NB_REG  register-file reads for rs / rt
- i_imm  in  NB_REG  sign-extended immediate
- i_rs / i_rt / i_rd  in  NB_REG_ADDR  source and destination addresses
- i_opcode  in  NB_OPCODE  decoded opcode
- i_we / i_mem_read / i_rinst / i_jinst  in  1  reg write, load, R-type, jump
- i_fwd_mux_a / i_fwd_mux_b  in  1  forwarding select from the forwarding unit
- i_fwd_data_a / i_fwd_data_b  in  NB_REG  forwarded values
- o_stall  out  1  hold PC and IF/ID this cycle
- o_valid_ex  out  1  EX instruction is real
- o_data_a / o_data_b / o_imm  out  NB_REG  EX operands
- o_rs_ex / o_rt_ex / o_rd_ex  out  NB_REG_ADDR  EX addresses
- o_opcode_ex  out  NB_OPCODE
- o_we_ex / o_mem_read_ex / o_rinst_ex / o_jinst_ex  out  1  EX control
- o_stall_count  out  NB_STALL_CNT  saturating count of bubbles inserted

## Operation
- Operand capture: o_data_a <= i_fwd_mux_a ? i_fwd_data_a : i_data_a. B is selected the same way.
- Write-enable hygiene: o_we_ex <= i_we & (i_rd != 0) & i_valid. A bubble or r0 destination never produces a forwarding match downstream.
- Load-use hazard (combinational, sub-module): hz = o_valid_ex & o_mem_read_ex & (o_rd_ex != 0) & i_valid & ~i_jinst & ((i_rs == o_rd_ex) | (i_rinst & (i_rt == o_rd_ex))).
- o_stall = hz & ~i_flush & i_enable.
- Next-state priority when i_enable=1:
  1. i_flush: load bubble (o_valid_ex=0, o_we_ex=0, o_mem_read_ex=0; data fields don't-care, hold them). No stall and no count.
  2. hz: load the same bubble. IF/ID is held externally, so the same ID instruction is re-presented next cycle. The load has moved to MEM, so forwarding now serves it and hz deasserts. Each stall therefore lasts exactly one cycle.
  3. Otherwise: capture ID fields. o_valid_ex <= i_valid.
- i_enable=0: every register holds, o_stall=0, counter holds.
- Stall counter: increments by 1 on each cycle where o_stall=1. It saturates at all-ones and does not wrap.
- Effective states: RUN (capture) and BUBBLE (bubble loaded). BUBBLE always returns to RUN or to a flush bubble; two consecutive hazard bubbles for one instruction are impossible.

## Timing
- Reset (i_reset=0, asynchronous): all outputs 0, including o_valid_ex, the counter, and o_stall. Reset deasserts synchronously to the design.
- ID -> EX latency: 1 cycle. o_stall is combinational from registered EX state and current ID inputs, and is valid in the same cycle.
- Flush and hazard in the same cycle: flush wins; o_stall=0.
- Reset mid-stall: the bubble is discarded and o_valid_ex=0 immediately; the re-presented instruction is captured normally after reset.

## Structure
- Shared package mips_pkg: NB_REG, NB_REG_ADDR, NB_OPCODE, and the ID/EX control bundle field ordering shared with the forwarding unit and the EX/MEM latch.
- One sub-module: load_use_detector (pure combinational hz equation). It is reused by a future branch-in-ID hazard path.
- The counter stays inline.

## Test plan
- Reset with all inputs nonzero -> every output 0. Release reset, then i_valid=1, i_data_a=0x11, i_rd=3, i_we=1 -> next cycle o_data_a=0x11, o_we_ex=1, o_valid_ex=1.
- i_fwd_mux_a=1, i_fwd_data_a=0xDEAD, i_data_a=0x1 -> o_data_a=0xDEAD. A write to r0 -> o_we_ex=0.
- EX holds lw r5, ID holds add r6,r5,r2 -> o_stall=1 for exactly one cycle, then o_valid_ex=0 and count=1. The following cycle captures the add and o_stall=0.
- Load-use hazard with i_flush=1 in the same cycle -> o_stall=0, bubble loaded, count unchanged.
- i_enable=0 during a hazard -> o_stall=0 and all outputs frozen for 3 cycles. Re-enable -> the stall occurs once.
- Force the counter to 0xFFFF via repeated stalls -> it stays 0xFFFF. Asserting reset mid-stall -> counter 0 and o_valid_ex=0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Widths and ID/EX bundle layout shared by the forwarding unit, ID/EX and EX/MEM latches.
// Field order of ex_ctrl_t is relied on by the downstream latches; append, never reorder.
package mips_pkg;

   localparam int NB_REG      = 32;
   localparam int NB_REG_ADDR = 5;
   localparam int NB_OPCODE   = 6;

   typedef struct packed {
      logic we;
      logic mem_read;
      logic rinst;
      logic jinst;
   } ex_ctrl_t;

   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_CAPTURE = 2'd2
   } latch_act_t;

endpackage

// File: rtl/id_ex_latch_load_use.sv
// Load-use hazard detector: an EX-stage load whose destination feeds the ID instruction
// cannot be forwarded in time, so one bubble is required.
module load_use_detector #(
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   valid_ex,
   input  logic                   mem_read_ex,
   input  logic [NB_REG_ADDR-1:0] rd_ex,
   input  logic                   valid,
   input  logic                   jinst,
   input  logic                   rinst,
   input  logic [NB_REG_ADDR-1:0] rs,
   input  logic [NB_REG_ADDR-1:0] rt,
   output logic                   hz
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (rs == rd_ex);
   // rt is only a source operand for R-type instructions
   assign rt_match = rinst & (rt == rd_ex);

   assign hz = valid_ex & mem_read_ex & (rd_ex != '0) & valid & ~jinst & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: forwarded operand capture, load-use bubble insertion,
// EX flush, debug-step hold and a saturating stall counter.
module id_ex_latch #(
   parameter int NB_REG_ADDR  = mips_pkg::NB_REG_ADDR,
   parameter int NB_REG       = mips_pkg::NB_REG,
   parameter int NB_OPCODE    = mips_pkg::NB_OPCODE,
   parameter int NB_STALL_CNT = 16
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_flush,
   input  logic                    i_valid,
   input  logic [NB_REG-1:0]       i_data_a,
   input  logic [NB_REG-1:0]       i_data_b,
   input  logic [NB_REG-1:0]       i_imm,
   input  logic [NB_REG_ADDR-1:0]  i_rs,
   input  logic [NB_REG_ADDR-1:0]  i_rt,
   input  logic [NB_REG_ADDR-1:0]  i_rd,
   input  logic [NB_OPCODE-1:0]    i_opcode,
   input  logic                    i_we,
   input  logic                    i_mem_read,
   input  logic                    i_rinst,
   input  logic                    i_jinst,
   input  logic                    i_fwd_mux_a,
   input  logic                    i_fwd_mux_b,
   input  logic [NB_REG-1:0]       i_fwd_data_a,
   input  logic [NB_REG-1:0]       i_fwd_data_b,
   output logic                    o_stall,
   output logic                    o_valid_ex,
   output logic [NB_REG-1:0]       o_data_a,
   output logic [NB_REG-1:0]       o_data_b,
   output logic [NB_REG-1:0]       o_imm,
   output logic [NB_REG_ADDR-1:0]  o_rs_ex,
   output logic [NB_REG_ADDR-1:0]  o_rt_ex,
   output logic [NB_REG_ADDR-1:0]  o_rd_ex,
   output logic [NB_OPCODE-1:0]    o_opcode_ex,
   output logic                    o_we_ex,
   output logic                    o_mem_read_ex,
   output logic                    o_rinst_ex,
   output logic                    o_jinst_ex,
   output logic [NB_STALL_CNT-1:0] o_stall_count
);

   import mips_pkg::*;

   logic                    valid_reg;
   logic [NB_REG-1:0]       data_a_reg;
   logic [NB_REG-1:0]       data_b_reg;
   logic [NB_REG-1:0]       imm_reg;
   logic [NB_REG_ADDR-1:0]  rs_reg;
   logic [NB_REG_ADDR-1:0]  rt_reg;
   logic [NB_REG_ADDR-1:0]  rd_reg;
   logic [NB_OPCODE-1:0]    opcode_reg;
   ex_ctrl_t                ctrl_reg;
   logic [NB_STALL_CNT-1:0] stall_cnt_reg;
   logic                    hz;
   latch_act_t              act;

   load_use_detector #(
      .NB_REG_ADDR (NB_REG_ADDR)
   ) u_load_use (
      .valid_ex    (valid_reg),
      .mem_read_ex (ctrl_reg.mem_read),
      .rd_ex       (rd_reg),
      .valid       (i_valid),
      .jinst       (i_jinst),
      .rinst       (i_rinst),
      .rs          (i_rs),
      .rt          (i_rt),
      .hz          (hz)
   );

   // Flush outranks the hazard: a squashed instruction never needs to stall.
   always_comb begin
      act = ACT_HOLD;
      if (i_enable) begin
         if (i_flush || hz) begin
            act = ACT_BUBBLE;
         end else begin
            act = ACT_CAPTURE;
         end
      end
   end

   assign o_stall = hz & ~i_flush & i_enable;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         valid_reg  <= 1'b0;
         data_a_reg <= '0;
         data_b_reg <= '0;
         imm_reg    <= '0;
         rs_reg     <= '0;
         rt_reg     <= '0;
         rd_reg     <= '0;
         opcode_reg <= '0;
         ctrl_reg   <= '0;
      end else begin
         case (act)
            ACT_BUBBLE: begin
               valid_reg         <= 1'b0;
               ctrl_reg.we       <= 1'b0;
               ctrl_reg.mem_read <= 1'b0;
            end
            ACT_CAPTURE: begin
               valid_reg         <= i_valid;
               data_a_reg        <= i_fwd_mux_a ? i_fwd_data_a : i_data_a;
               data_b_reg        <= i_fwd_mux_b ? i_fwd_data_b : i_data_b;
               imm_reg           <= i_imm;
               rs_reg            <= i_rs;
               rt_reg            <= i_rt;
               rd_reg            <= i_rd;
               opcode_reg        <= i_opcode;
               // r0 writes and bubbles must never match in the forwarding unit
               ctrl_reg.we       <= i_we & (i_rd != '0) & i_valid;
               ctrl_reg.mem_read <= i_mem_read;
               ctrl_reg.rinst    <= i_rinst;
               ctrl_reg.jinst    <= i_jinst;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         stall_cnt_reg <= '0;
      end else if (o_stall && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign o_valid_ex    = valid_reg;
   assign o_data_a      = data_a_reg;
   assign o_data_b      = data_b_reg;
   assign o_imm         = imm_reg;
   assign o_rs_ex       = rs_reg;
   assign o_rt_ex       = rt_reg;
   assign o_rd_ex       = rd_reg;
   assign o_opcode_ex   = opcode_reg;
   assign o_we_ex       = ctrl_reg.we;
   assign o_mem_read_ex = ctrl_reg.mem_read;
   assign o_rinst_ex    = ctrl_reg.rinst;
   assign o_jinst_ex    = ctrl_reg.jinst;
   assign o_stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_latch.sv
// Bench for id_ex_latch: directed scenarios plus randomized traffic against a
// behavioural model of the EX-stage contents.
module tb_id_ex_latch;

   localparam int CNTW    = 6;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   logic        i_clock = 1'b0;
   logic        i_reset, i_enable, i_flush, i_valid;
   logic [31:0] i_data_a, i_data_b, i_imm, i_fwd_data_a, i_fwd_data_b;
   logic [4:0]  i_rs, i_rt, i_rd;
   logic [5:0]  i_opcode;
   logic        i_we, i_mem_read, i_rinst, i_jinst, i_fwd_mux_a, i_fwd_mux_b;

   logic            o_stall, o_valid_ex, o_we_ex, o_mem_read_ex, o_rinst_ex, o_jinst_ex;
   logic [31:0]     o_data_a, o_data_b, o_imm;
   logic [4:0]      o_rs_ex, o_rt_ex, o_rd_ex;
   logic [5:0]      o_opcode_ex;
   logic [CNTW-1:0] o_stall_count;

   id_ex_latch #(.NB_STALL_CNT(CNTW)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
      .i_valid(i_valid), .i_data_a(i_data_a), .i_data_b(i_data_b), .i_imm(i_imm),
      .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_opcode(i_opcode), .i_we(i_we),
      .i_mem_read(i_mem_read), .i_rinst(i_rinst), .i_jinst(i_jinst),
      .i_fwd_mux_a(i_fwd_mux_a), .i_fwd_mux_b(i_fwd_mux_b),
      .i_fwd_data_a(i_fwd_data_a), .i_fwd_data_b(i_fwd_data_b),
      .o_stall(o_stall), .o_valid_ex(o_valid_ex), .o_data_a(o_data_a), .o_data_b(o_data_b),
      .o_imm(o_imm), .o_rs_ex(o_rs_ex), .o_rt_ex(o_rt_ex), .o_rd_ex(o_rd_ex),
      .o_opcode_ex(o_opcode_ex), .o_we_ex(o_we_ex), .o_mem_read_ex(o_mem_read_ex),
      .o_rinst_ex(o_rinst_ex), .o_jinst_ex(o_jinst_ex), .o_stall_count(o_stall_count)
   );

   always #5 i_clock = ~i_clock;

   int errors = 0;
   int checks = 0;

   // Expected EX-stage contents
   logic        m_valid, m_we, m_mr, m_ri, m_ji;
   logic [31:0] m_a, m_b, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [5:0]  m_op;
   int          m_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      {m_valid, m_we, m_mr, m_ri, m_ji} = '0;
      m_a = '0; m_b = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_op = '0;
      m_cnt = 0;
   endtask

   function automatic logic exp_hazard();
      logic src_hit;
      src_hit = (i_rs == m_rd) || (i_rinst && (i_rt == m_rd));
      return m_valid && m_mr && (m_rd != 0) && i_valid && !i_jinst && src_hit;
   endfunction

   function automatic logic exp_stall();
      return exp_hazard() && !i_flush && i_enable;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, o_valid_ex, m_valid);
      check({tag, ".we"}, o_we_ex, m_we);
      check({tag, ".mr"}, o_mem_read_ex, m_mr);
      check({tag, ".cnt"}, o_stall_count, m_cnt);
      if (m_valid) begin
         check({tag, ".a"}, o_data_a, m_a);
         check({tag, ".b"}, o_data_b, m_b);
         check({tag, ".imm"}, o_imm, m_imm);
         check({tag, ".addr"}, {o_rs_ex, o_rt_ex, o_rd_ex}, {m_rs, m_rt, m_rd});
         check({tag, ".op"}, o_opcode_ex, m_op);
         check({tag, ".ri_ji"}, {o_rinst_ex, o_jinst_ex}, {m_ri, m_ji});
      end
   endtask

   // One clock: check o_stall, advance the model, check registered outputs after the edge.
   task automatic cycle(input string tag);
      logic hz, st;
      #1;
      hz = exp_hazard();
      st = exp_stall();
      check({tag, ".stall"}, o_stall, st);
      @(posedge i_clock);
      if (i_enable) begin
         if (i_flush || hz) begin
            m_valid = 1'b0; m_we = 1'b0; m_mr = 1'b0;
         end else begin
            m_valid = i_valid;
            m_a     = i_fwd_mux_a ? i_fwd_data_a : i_data_a;
            m_b     = i_fwd_mux_b ? i_fwd_data_b : i_data_b;
            m_imm   = i_imm;
            m_rs = i_rs; m_rt = i_rt; m_rd = i_rd; m_op = i_opcode;
            m_we    = i_we && i_valid && (i_rd != 0);
            m_mr = i_mem_read; m_ri = i_rinst; m_ji = i_jinst;
         end
         if (st && m_cnt < CNT_MAX) m_cnt++;
      end
      #1;
      check_outputs(tag);
      $display("cyc %s en=%0b fl=%0b stall=%0b valid_ex=%0b rd_ex=%0d cnt=%0d",
               tag, i_enable, i_flush, st, o_valid_ex, o_rd_ex, o_stall_count);
   endtask

   task automatic idle_inputs();
      i_enable = 1; i_flush = 0; i_valid = 0;
      i_data_a = 0; i_data_b = 0; i_imm = 0; i_fwd_data_a = 0; i_fwd_data_b = 0;
      i_rs = 0; i_rt = 0; i_rd = 0; i_opcode = 0;
      i_we = 0; i_mem_read = 0; i_rinst = 0; i_jinst = 0; i_fwd_mux_a = 0; i_fwd_mux_b = 0;
   endtask

   task automatic put_lw(input logic [4:0] rd);
      idle_inputs();
      i_valid = 1; i_opcode = 6'h23; i_rs = 5'd1; i_rd = rd; i_rt = rd;
      i_we = 1; i_mem_read = 1; i_imm = 32'h10;
   endtask

   task automatic put_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      idle_inputs();
      i_valid = 1; i_opcode = 6'h00; i_rinst = 1; i_we = 1;
      i_rs = rs; i_rt = rt; i_rd = rd; i_data_a = 32'h100; i_data_b = 32'h200;
   endtask

   initial begin
      // Reset with every input nonzero
      i_reset = 0;
      i_enable = 1; i_flush = 1; i_valid = 1;
      i_data_a = '1; i_data_b = '1; i_imm = '1; i_fwd_data_a = '1; i_fwd_data_b = '1;
      i_rs = '1; i_rt = '1; i_rd = '1; i_opcode = '1;
      i_we = 1; i_mem_read = 1; i_rinst = 1; i_jinst = 1; i_fwd_mux_a = 1; i_fwd_mux_b = 1;
      model_reset();
      repeat (2) @(posedge i_clock);
      #1;
      check("rst.stall", o_stall, 1'b0);
      check_outputs("rst");
      check("rst.all", {o_data_a, o_data_b, o_imm, o_rs_ex, o_rt_ex, o_rd_ex, o_opcode_ex,
                        o_rinst_ex, o_jinst_ex} == '0, 1'b1);
      i_reset = 1;

      idle_inputs();
      i_valid = 1; i_data_a = 32'h11; i_rd = 5'd3; i_we = 1;
      cycle("cap");
      check("cap.a_const", o_data_a, 32'h11);
      check("cap.we_const", o_we_ex, 1'b1);

      i_fwd_mux_a = 1; i_fwd_data_a = 32'hDEAD; i_data_a = 32'h1;
      cycle("fwd");
      check("fwd.a_const", o_data_a, 32'hDEAD);

      idle_inputs();
      i_valid = 1; i_rd = 0; i_we = 1; i_fwd_mux_b = 1; i_fwd_data_b = 32'hBEEF;
      cycle("r0");
      check("r0.we_const", o_we_ex, 1'b0);
      check("r0.b_const", o_data_b, 32'hBEEF);

      // Load-use: lw r5 then add r6,r5,r2
      put_lw(5'd5);
      cycle("lw");
      put_add(5'd6, 5'd5, 5'd2);
      #1 check("lu.stall_const", o_stall, 1'b1);
      cycle("lu.bubble");
      check("lu.cnt_const", o_stall_count, 1);
      cycle("lu.retry");
      check("lu.rd_const", o_rd_ex, 5'd6);

      // rt-only dependence on a non-R-type does not stall
      put_lw(5'd7);
      cycle("lw2");
      put_add(5'd8, 5'd2, 5'd7);
      i_rinst = 0;
      cycle("rt_nonr");

      // Flush together with hazard
      put_lw(5'd5);
      cycle("lw3");
      put_add(5'd6, 5'd2, 5'd5);
      i_flush = 1;
      cycle("flush_hz");
      check("flush.cnt_const", o_stall_count, 1);

      // Debug hold during a hazard
      put_lw(5'd9);
      cycle("lw4");
      put_add(5'd10, 5'd9, 5'd9);
      i_enable = 0;
      for (int k = 0; k < 3; k++) cycle("hold");
      i_enable = 1;
      cycle("hold.stall");
      cycle("hold.retry");

      // Saturate the counter
      for (int k = 0; k < CNT_MAX + 6; k++) begin
         put_lw(5'd4);
         cycle("sat.lw");
         put_add(5'd11, 5'd4, 5'd3);
         cycle("sat.add");
      end
      check("sat.cnt_const", o_stall_count, CNT_MAX);

      // Asynchronous reset in the middle of a stall
      put_lw(5'd12);
      cycle("lw5");
      put_add(5'd13, 5'd12, 5'd0);
      #2;
      check("mid.stall_pre", o_stall, 1'b1);
      i_reset = 0;
      model_reset();
      #1;
      check("mid.valid", o_valid_ex, 1'b0);
      check("mid.cnt", o_stall_count, 0);
      check("mid.stall", o_stall, 1'b0);
      #1 i_reset = 1;
      cycle("mid.retry");
      check("mid.rd_const", o_rd_ex, 5'd13);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         i_enable     = ($urandom_range(0, 99) < 85);
         i_flush      = ($urandom_range(0, 99) < 10);
         i_valid      = ($urandom_range(0, 99) < 85);
         i_data_a     = $urandom; i_data_b = $urandom; i_imm = $urandom;
         i_fwd_data_a = $urandom; i_fwd_data_b = $urandom;
         i_fwd_mux_a  = $urandom_range(0, 1); i_fwd_mux_b = $urandom_range(0, 1);
         i_rs = 5'($urandom_range(0, 3)); i_rt = 5'($urandom_range(0, 3));
         i_rd = 5'($urandom_range(0, 3));
         i_opcode = 6'($urandom);
         i_we = $urandom_range(0, 1); i_mem_read = $urandom_range(0, 1);
         i_rinst = $urandom_range(0, 1); i_jinst = ($urandom_range(0, 99) < 15);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
